// File: rtl/tinyriscv_pkg.sv
// Shared RV32I definitions for the load/store path: opcodes, funct3 size codes, LSU states.
// Pure declarations; no timing or flow control of its own.
// The access-check helper is shared by the LSU and anything else that needs the same decode.
package tinyriscv_pkg;

    localparam int RISCV_CONFIG_XLEN = 32;

    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        LSU_IDLE,
        LSU_REQ,
        LSU_WAIT,
        LSU_RESP
    } lsu_state_e;

    // 1 when the access must trap: unknown opcode/size, or a misaligned halfword/word.
    function automatic logic lsu_exc(input logic [6:0] opcode,
                                     input logic [2:0] funct3,
                                     input logic [1:0] addr_lo);
        logic legal;
        logic misaligned;
        legal = 1'b0;
        if (opcode == OPC_LOAD)
            legal = funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU};
        else if (opcode == OPC_STORE)
            legal = funct3 inside {F3_B, F3_H, F3_W};
        misaligned = ((funct3[1:0] == 2'b01) && addr_lo[0]) ||
                     ((funct3[1:0] == 2'b10) && (addr_lo != 2'b00));
        return !legal || misaligned;
    endfunction

endpackage

// File: rtl/tinyriscv_lsu_if.sv
// Execute-stage request/response and data-bus signals of the LSU.
// No logic; master is the LSU side, slave is the core plus memory side.
// Request uses valid/ready, bus uses req/gnt then rvalid.
interface tinyriscv_lsu_if #(
    parameter int XLEN = tinyriscv_pkg::RISCV_CONFIG_XLEN
);
    logic            req_valid;
    logic            req_ready;
    logic [6:0]      req_opcode;
    logic [2:0]      req_funct3;
    logic [XLEN-1:0] req_addr;
    logic [XLEN-1:0] req_wdata;

    logic            rsp_valid;
    logic [XLEN-1:0] rsp_data;
    logic            rsp_exc;

    logic            mem_req;
    logic            mem_we;
    logic [XLEN-1:0] mem_addr;
    logic [XLEN-1:0] mem_wdata;
    logic [3:0]      mem_be;
    logic            mem_gnt;
    logic            mem_rvalid;
    logic [XLEN-1:0] mem_rdata;

    modport master (
        input  req_valid, req_opcode, req_funct3, req_addr, req_wdata,
        output req_ready,
        output rsp_valid, rsp_data, rsp_exc,
        output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        input  mem_gnt, mem_rvalid, mem_rdata
    );

    modport slave (
        output req_valid, req_opcode, req_funct3, req_addr, req_wdata,
        input  req_ready,
        input  rsp_valid, rsp_data, rsp_exc,
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        output mem_gnt, mem_rvalid, mem_rdata
    );

endinterface

// File: rtl/tinyriscv_lsu_align.sv
// Byte-lane steering: store byte enables/replication and load shift/extension.
// Purely combinational, zero latency.
// No flow control; the LSU FSM decides when outputs are used.
module tinyriscv_lsu_align
    import tinyriscv_pkg::*;
#(
    parameter int XLEN = RISCV_CONFIG_XLEN
) (
    input  logic [2:0]      funct3,
    input  logic [1:0]      addr_lo,
    input  logic [XLEN-1:0] wdata,
    input  logic [XLEN-1:0] rdata,
    output logic [3:0]      be,
    output logic [XLEN-1:0] wdata_lane,
    output logic [XLEN-1:0] rdata_ext
);

    logic [XLEN-1:0] rdata_sh;

    assign rdata_sh = rdata >> {addr_lo, 3'b000};

    // Store data is replicated to every lane so be alone selects the target bytes.
    always_comb begin
        be         = 4'b1111;
        wdata_lane = wdata;
        case (funct3[1:0])
            2'b00: begin
                be         = 4'b0001 << addr_lo;
                wdata_lane = {4{wdata[7:0]}};
            end
            2'b01: begin
                be         = 4'b0011 << {addr_lo[1], 1'b0};
                wdata_lane = {2{wdata[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        rdata_ext = rdata_sh;
        case (funct3)
            F3_B:    rdata_ext = {{(XLEN-8){rdata_sh[7]}}, rdata_sh[7:0]};
            F3_H:    rdata_ext = {{(XLEN-16){rdata_sh[15]}}, rdata_sh[15:0]};
            F3_BU:   rdata_ext = {{(XLEN-8){1'b0}}, rdata_sh[7:0]};
            F3_HU:   rdata_ext = {{(XLEN-16){1'b0}}, rdata_sh[15:0]};
            default: rdata_ext = rdata_sh;
        endcase
    end

endmodule

// File: rtl/tinyriscv_lsu.sv
// RV32I load/store unit: one access at a time from execute stage to a req/gnt data bus.
// Latency: exception 1 cycle, store 2 + gnt stalls, load 3 + gnt stalls + rvalid wait.
// Backpressure: req_ready only in IDLE; mem_req and its fields held until mem_gnt.
module tinyriscv_lsu
    import tinyriscv_pkg::*;
#(
    parameter int XLEN = RISCV_CONFIG_XLEN
) (
    input  logic            clk,
    input  logic            rst_n,
    tinyriscv_lsu_if.master bus
);

    lsu_state_e      state;
    lsu_state_e      state_nxt;
    logic [6:0]      opcode_q;
    logic [2:0]      funct3_q;
    logic [XLEN-1:0] addr_q;
    logic [XLEN-1:0] wdata_q;
    logic [XLEN-1:0] rsp_data_q;
    logic            rsp_exc_q;

    logic            accept;
    logic            req_exc;
    logic            is_store_q;
    logic [3:0]      be;
    logic [XLEN-1:0] wdata_lane;
    logic [XLEN-1:0] rdata_ext;

    assign accept     = bus.req_valid && (state == LSU_IDLE);
    assign req_exc    = lsu_exc(bus.req_opcode, bus.req_funct3, bus.req_addr[1:0]);
    assign is_store_q = (opcode_q == OPC_STORE);

    tinyriscv_lsu_align #(.XLEN(XLEN)) u_align (
        .funct3     (funct3_q),
        .addr_lo    (addr_q[1:0]),
        .wdata      (wdata_q),
        .rdata      (bus.mem_rdata),
        .be         (be),
        .wdata_lane (wdata_lane),
        .rdata_ext  (rdata_ext)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= LSU_IDLE;
        else        state <= state_nxt;
    end

    // Bus outputs are gated by state so nothing leaks onto the bus outside REQ.
    always_comb begin
        state_nxt      = state;
        bus.req_ready  = 1'b0;
        bus.rsp_valid  = 1'b0;
        bus.mem_req    = 1'b0;
        bus.mem_we     = 1'b0;
        bus.mem_addr   = '0;
        bus.mem_wdata  = '0;
        bus.mem_be     = '0;
        case (state)
            LSU_IDLE: begin
                bus.req_ready = 1'b1;
                if (bus.req_valid) state_nxt = req_exc ? LSU_RESP : LSU_REQ;
            end
            LSU_REQ: begin
                bus.mem_req   = 1'b1;
                bus.mem_we    = is_store_q;
                bus.mem_addr  = {addr_q[XLEN-1:2], 2'b00};
                bus.mem_wdata = wdata_lane;
                bus.mem_be    = be;
                if (bus.mem_gnt) state_nxt = is_store_q ? LSU_RESP : LSU_WAIT;
            end
            LSU_WAIT: begin
                if (bus.mem_rvalid) state_nxt = LSU_RESP;
            end
            LSU_RESP: begin
                bus.rsp_valid = 1'b1;
                state_nxt     = LSU_IDLE;
            end
            default: state_nxt = LSU_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            opcode_q   <= '0;
            funct3_q   <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rsp_data_q <= '0;
            rsp_exc_q  <= 1'b0;
        end else begin
            if (accept) begin
                opcode_q <= bus.req_opcode;
                funct3_q <= bus.req_funct3;
                addr_q   <= bus.req_addr;
                wdata_q  <= bus.req_wdata;
            end
            // Response registers only change on entry to RESP and hold otherwise.
            if (accept && req_exc) begin
                rsp_data_q <= '0;
                rsp_exc_q  <= 1'b1;
            end else if ((state == LSU_REQ) && bus.mem_gnt && is_store_q) begin
                rsp_data_q <= '0;
                rsp_exc_q  <= 1'b0;
            end else if ((state == LSU_WAIT) && bus.mem_rvalid) begin
                rsp_data_q <= rdata_ext;
                rsp_exc_q  <= 1'b0;
            end
        end
    end

    assign bus.rsp_data = rsp_data_q;
    assign bus.rsp_exc  = rsp_exc_q;

endmodule

// File: tb/tb_tinyriscv_lsu.sv
// Scoreboard bench for tinyriscv_lsu: byte-level memory reference model, bus responder, response monitor.
module tb_tinyriscv_lsu;

    localparam logic [6:0] LD = 7'b0000011;
    localparam logic [6:0] ST = 7'b0100011;

    typedef struct {
        logic [31:0] data;
        logic        exc;
        int          lat;
        int          acc;
    } rsp_exp_t;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        int          stall;
        int          rv;
    } mem_exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc   = 0;
    int   n_checks = 0;
    int   n_fail   = 0;
    bit   noise    = 1'b0;

    rsp_exp_t rsp_q[$];
    mem_exp_t mem_q[$];
    logic [7:0]  ref_mem [int unsigned];
    logic [31:0] bus_mem [int unsigned];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    tinyriscv_lsu_if #(.XLEN(32)) bus ();

    tinyriscv_lsu #(.XLEN(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [7:0] init_byte(input logic [31:0] a);
        logic [31:0] t;
        t = a * 32'd37 + 32'd11;
        return t[7:0];
    endfunction

    function automatic logic [7:0] ref_rd(input logic [31:0] a);
        if (ref_mem.exists(a)) return ref_mem[a];
        return init_byte(a);
    endfunction

    function automatic logic [31:0] bus_rd(input logic [31:0] wa);
        if (bus_mem.exists(wa)) return bus_mem[wa];
        return {init_byte(wa + 3), init_byte(wa + 2), init_byte(wa + 1), init_byte(wa)};
    endfunction

    task automatic preload(input logic [31:0] wa, input logic [31:0] word);
        bus_mem[wa] = word;
        for (int k = 0; k < 4; k++) ref_mem[wa + k] = word[8*k +: 8];
    endtask

    // Reference model: expectations straight from the ISA rules on a byte-addressed memory.
    task automatic send(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] w, input int d, input int r);
        int          size;
        int          g;
        int          n;
        logic        legal;
        logic [31:0] res;
        logic [31:0] wd;
        logic [3:0]  be;
        mem_exp_t    m;
        rsp_exp_t    e;

        size = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        if (op == LD)      legal = (f3 != 3'd3) && (f3 != 3'd6) && (f3 != 3'd7);
        else if (op == ST) legal = (f3 <= 3'd2);
        else               legal = 1'b0;
        if ((a % size) != 0) legal = 1'b0;
        be = 4'(((1 << size) - 1) << (a % 4));

        @(negedge clk);
        g = 0;
        while (!bus.req_ready && g < 50) begin @(negedge clk); g++; end
        if (!bus.req_ready) check("req_ready_timeout", 32'(bus.req_ready), 32'd1);
        n = cyc;

        if (!legal) begin
            e = '{data: 32'd0, exc: 1'b1, lat: 1, acc: n};
        end else if (op == ST) begin
            for (int i = 0; i < 4; i++) wd[8*i +: 8] = w[8*(i % size) +: 8];
            for (int k = 0; k < size; k++) ref_mem[a + k] = w[8*k +: 8];
            m = '{we: 1'b1, addr: a & ~32'd3, be: be, wdata: wd, stall: d, rv: r};
            mem_q.push_back(m);
            e = '{data: 32'd0, exc: 1'b0, lat: 2 + d, acc: n};
        end else begin
            res = 32'd0;
            for (int k = 0; k < size; k++) res[8*k +: 8] = ref_rd(a + k);
            if (!f3[2] && size == 1 && res[7])  res = res | 32'hFFFF_FF00;
            if (!f3[2] && size == 2 && res[15]) res = res | 32'hFFFF_0000;
            m = '{we: 1'b0, addr: a & ~32'd3, be: be, wdata: 32'd0, stall: d, rv: r};
            mem_q.push_back(m);
            e = '{data: res, exc: 1'b0, lat: 3 + d + r, acc: n};
        end
        rsp_q.push_back(e);

        bus.req_opcode = op;
        bus.req_funct3 = f3;
        bus.req_addr   = a;
        bus.req_wdata  = w;
        bus.req_valid  = 1'b1;
        @(posedge clk);
        #1;
        bus.req_valid  = 1'b0;
        bus.req_addr   = $urandom();
        bus.req_wdata  = $urandom();
    endtask

    task automatic drain();
        int g;
        g = 0;
        while ((rsp_q.size() != 0 || mem_q.size() != 0) && g < 60) begin @(negedge clk); g++; end
        if (rsp_q.size() != 0 || mem_q.size() != 0) begin
            check("drain_timeout", 32'(rsp_q.size() + mem_q.size()), 32'd0);
            rsp_q.delete();
            mem_q.delete();
        end
        @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_ready"}, 32'(bus.req_ready), 32'd1);
        check({tag, "_mem_req"},   32'(bus.mem_req),   32'd0);
        check({tag, "_mem_we"},    32'(bus.mem_we),    32'd0);
        check({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 32'd0);
        check({tag, "_rsp_exc"},   32'(bus.rsp_exc),   32'd0);
        check({tag, "_rsp_data"},  bus.rsp_data,       32'd0);
        check({tag, "_mem_addr"},  bus.mem_addr,       32'd0);
        check({tag, "_mem_wdata"}, bus.mem_wdata,      32'd0);
        check({tag, "_mem_be"},    32'(bus.mem_be),    32'd0);
    endtask

    // Memory responder: checks every cycle of a pending bus request against the expected access.
    initial begin
        int          stall;
        int          req_cycles;
        bit          rv_pending;
        int          rv_cnt;
        logic [31:0] rv_word;
        logic [31:0] w;
        mem_exp_t    e;
        stall = 0; req_cycles = 0; rv_pending = 0; rv_cnt = 0; rv_word = 0;
        bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = '0;
        forever begin
            @(negedge clk);
            bus.mem_gnt    = 1'b0;
            bus.mem_rvalid = 1'b0;
            bus.mem_rdata  = $urandom();
            if (!rst_n) begin stall = 0; req_cycles = 0; end
            if (rv_pending) begin
                if (rv_cnt == 0) begin
                    bus.mem_rvalid = 1'b1;
                    bus.mem_rdata  = rv_word;
                    rv_pending     = 1'b0;
                end else rv_cnt--;
            end else if (noise && $urandom_range(0, 7) == 0) begin
                bus.mem_rvalid = 1'b1;
            end
            if (bus.mem_req) begin
                if (mem_q.size() == 0) begin
                    check("mem_req_unexpected", 32'(bus.mem_req), 32'd0);
                end else begin
                    e = mem_q[0];
                    req_cycles++;
                    check("mem_we",   32'(bus.mem_we), 32'(e.we));
                    check("mem_addr", bus.mem_addr,    e.addr);
                    check("mem_be",   32'(bus.mem_be), 32'(e.be));
                    if (e.we) check("mem_wdata", bus.mem_wdata, e.wdata);
                    if (stall >= e.stall) begin
                        bus.mem_gnt = 1'b1;
                        check("mem_req_hold_cycles", 32'(req_cycles), 32'(e.stall + 1));
                        stall = 0;
                        req_cycles = 0;
                        void'(mem_q.pop_front());
                        if (e.we) begin
                            w = bus_rd(bus.mem_addr);
                            for (int k = 0; k < 4; k++)
                                if (bus.mem_be[k]) w[8*k +: 8] = bus.mem_wdata[8*k +: 8];
                            bus_mem[bus.mem_addr] = w;
                        end else begin
                            rv_pending = 1'b1;
                            rv_cnt     = e.rv;
                            rv_word    = bus_rd(bus.mem_addr);
                        end
                    end else stall++;
                end
            end
        end
    end

    // Response monitor: pops the scoreboard on rsp_valid, otherwise checks the outputs hold.
    initial begin
        logic [31:0] last_data;
        logic        last_exc;
        rsp_exp_t    e;
        last_data = 0; last_exc = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                last_data = 0;
                last_exc  = 0;
            end else if (bus.rsp_valid) begin
                if (rsp_q.size() == 0) begin
                    check("rsp_valid_unexpected", 32'(bus.rsp_valid), 32'd0);
                end else begin
                    e = rsp_q.pop_front();
                    check("rsp_data",    bus.rsp_data,       e.data);
                    check("rsp_exc",     32'(bus.rsp_exc),   32'(e.exc));
                    check("rsp_latency", 32'(cyc - e.acc),   32'(e.lat));
                end
                last_data = bus.rsp_data;
                last_exc  = bus.rsp_exc;
            end else begin
                check("rsp_data_hold", bus.rsp_data,     last_data);
                check("rsp_exc_hold",  32'(bus.rsp_exc), 32'(last_exc));
            end
        end
    end

    initial begin
        logic [6:0] op;
        logic [2:0] f3;
        int         sel;
        bus.req_valid  = 1'b0;
        bus.req_opcode = '0;
        bus.req_funct3 = '0;
        bus.req_addr   = '0;
        bus.req_wdata  = '0;

        repeat (3) @(negedge clk);
        check_reset_outputs("rst");
        rst_n = 1'b1;
        #1 check("ready_after_rst", 32'(bus.req_ready), 32'd1);

        send(ST, 3'b010, 32'h100, 32'hDEADBEEF, 0, 0); drain();
        preload(32'h100, 32'h80FF_0000);
        send(LD, 3'b000, 32'h103, 32'h0, 0, 0); drain();
        send(LD, 3'b100, 32'h103, 32'h0, 0, 1); drain();
        send(LD, 3'b001, 32'h101, 32'h0, 0, 0); drain();
        send(LD, 3'b010, 32'h102, 32'h0, 0, 0); drain();
        send(ST, 3'b001, 32'h202, 32'h1234ABCD, 3, 0); drain();
        send(LD, 3'b101, 32'h202, 32'h0, 1, 2); drain();
        send(LD, 3'b011, 32'h100, 32'h0, 0, 0); drain();

        // Abandon a load in WAIT; its late rvalid must not produce a response.
        send(LD, 3'b010, 32'h104, 32'h0, 0, 6);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        rsp_q.delete();
        mem_q.delete();
        #1 check_reset_outputs("rst_wait");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1 check("ready_after_mid_rst", 32'(bus.req_ready), 32'd1);
        repeat (12) @(negedge clk);

        noise = 1'b1;
        for (int i = 0; i < 250; i++) begin
            sel = $urandom_range(0, 9);
            if (sel < 4)      op = LD;
            else if (sel < 8) op = ST;
            else              op = 7'($urandom());
            f3 = (op == ST) ? 3'($urandom_range(0, 3)) : 3'($urandom_range(0, 7));
            send(op, f3, 32'h100 + $urandom_range(0, 63), $urandom(),
                 $urandom_range(0, 3), $urandom_range(0, 3));
            drain();
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        noise = 1'b0;
        repeat (4) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/tinyriscv_lsu.md
TINYRISCV_LSU -- requirements
Module: tinyriscv_lsu

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 Parameter XLEN, default `RISCV_CONFIG_XLEN (32): data/address width; only 32 supported, 4 byte lanes.
REQ-003 clk  in  1  single clock, rising edge.
REQ-004 rst_n  in  1  asynchronous active-low reset.
REQ-005 req_valid  in  1  execute stage presents a load/store.
REQ-006 req_ready  out  1  LSU accepts request (IDLE only).
REQ-007 req_opcode  in  7  RV32I opcode (LOAD or STORE).
REQ-008 req_funct3  in  3  access size/sign.
REQ-009 req_addr  in  XLEN  effective byte address (ALU result).
REQ-010 req_wdata  in  XLEN  store data (ALU bypass), lane 0 aligned.
REQ-011 rsp_valid  out  1  one-cycle completion pulse.
REQ-012 rsp_data  out  XLEN  extended load data; 0 for stores/exceptions.
REQ-013 rsp_exc  out  1  misaligned/illegal access, qualified by rsp_valid.
REQ-014 mem_req  out  1  bus request, held until mem_gnt.
REQ-015 mem_we  out  1  1 = write.
REQ-016 mem_addr  out  XLEN  word address, bits[1:0] = 0.
REQ-017 mem_wdata  out  XLEN  lane-replicated store data.
REQ-018 mem_be  out  4  byte enables.
REQ-019 mem_gnt  in  1  bus accepted request this cycle.
REQ-020 mem_rvalid  in  1  read data valid.
REQ-021 mem_rdata  in  XLEN  read word.

Function
REQ-022 FSM states SHALL be IDLE, REQ, WAIT, RESP; req_ready = (state==IDLE).
REQ-023 IDLE: on req_valid&req_ready, opcode, funct3, addr, wdata SHALL be latched.
REQ-024 Legal funct3: loads 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; stores 000 SB, 001 SH, 010 SW; anything else, or opcode not LOAD/STORE, is illegal.
REQ-025 Misaligned = halfword with addr[0]=1, or word with addr[1:0]!=0.
REQ-026 Illegal or misaligned: IDLE->RESP, rsp_exc=1, rsp_data=0, mem_req never asserted.
REQ-027 Legal: IDLE->REQ; mem_req=1 with stable mem_we/addr/wdata/be until the cycle mem_gnt=1.
REQ-028 REQ with mem_gnt: store ->RESP; load ->WAIT.
REQ-029 WAIT: on mem_rvalid capture extended data, ->RESP; mem_rvalid outside WAIT SHALL be ignored.
REQ-030 RESP: rsp_valid=1 exactly one cycle, then ->IDLE.
REQ-031 Latency (accept cycle N, gnt at N+1, rvalid at N+2): store rsp_valid at N+2, load at N+3, exception at N+1.
REQ-032 mem_be: SB 0001<<addr[1:0]; SH 0011<<{addr[1],1'b0}; SW 1111.
REQ-033 mem_wdata: SB {4{wdata[7:0]}}; SH {2{wdata[15:0]}}; SW wdata.
REQ-034 Load: rdata >> (addr[1:0]*8); LB/LH sign-extend bit 7/15; LBU/LHU zero-extend; LW unchanged.
REQ-035 rsp_data/rsp_exc SHALL hold until next RESP.

Reset
REQ-036 rst_n low SHALL force IDLE immediately; mem_req, mem_we, rsp_valid, rsp_exc, rsp_data, mem_addr, mem_wdata, mem_be = 0.
REQ-037 Reset mid-transaction SHALL abandon it; late mem_gnt/mem_rvalid produce no rsp_valid.
REQ-038 req_ready SHALL be 1 on the first cycle after reset release.

Structure
REQ-039 FSM state enum and load/store funct3 size codes SHALL live in shared package tinyriscv_pkg; opcodes come from the shared RV32I instruction-set definitions.
REQ-040 Lane steering/extension SHALL be a combinational sub-module tinyriscv_lsu_align.

Verification
REQ-041 SW addr 0x100, wdata 0xDEADBEEF, gnt immediate -> mem_addr 0x100, be 1111, rsp_valid at N+2, rsp_exc 0.
REQ-042 LB addr 0x103, rdata 0x80FF_0000 -> be 1000, rsp_data 0xFFFFFF80; LBU same -> 0x00000080.
REQ-043 LH addr 0x101 -> rsp_exc 1 at N+1, mem_req never high; LW addr 0x102 same.
REQ-044 SH addr 0x202, wdata 0x1234ABCD, gnt after 3 stall cycles -> mem_req held 4 cycles, mem_wdata 0xABCDABCD, be 1100.
REQ-045 Reset asserted in WAIT, rvalid after release -> no rsp_valid, req_ready 1.
REQ-046 funct3 011 with LOAD opcode -> rsp_exc 1, rsp_data 0.
